load_store_unit: RTL and testbench

- Initiator side of the data-memory interface: accepts one load/store request at a time from the core and drives address, write data and write enable to the byte-addressed data RAM.
- Data RAM: combinational 32-bit read of the 4 bytes starting at addr; writes 4 bytes at addr on the clock edge.
- Sub-word stores use a read-modify-write sequence. Loads return sign- or zero-extended data. Misaligned and reserved accesses are rejected with an error response.

---
 rtl/load_store_unit_if.sv | 47 ++++
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core-request, response and data-RAM signal bundle for the load/store unit.
// No storage; pure wiring between core, unit and RAM.
// Flow control: req_valid/req_ready handshake; response is a one-cycle pulse.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  // Core request channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  // Response pulse back to the core
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // Data RAM port (combinational read, clocked write)
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_write_enable;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [DATA_WIDTH-1:0] mem_read_data;

  // View of the load/store unit itself
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_write_enable, mem_write_data
  );

  // View of the environment: core issuing requests and RAM answering reads
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_write_enable, mem_write_data
  );

endinterface

// File: rtl/load_store_unit.sv
// Load/store initiator: one request at a time to a byte-addressed RAM, RMW for sub-word stores.
// Latency from acceptance: error 1, load 2, word store 2, sub-word store 3 cycles.
// Backpressure: req_ready only in IDLE; response is an unthrottled one-cycle pulse.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    STORE  = 3'd3,
    RESP   = 3'd4
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            size_q,  size_d;
  logic                  uns_q,   uns_d;
  logic                  err_q,   err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;

  logic accept;
  logic req_err;

  // Load data extension: sign bit is suppressed for unsigned loads
  function automatic logic [DATA_WIDTH-1:0] load_ext(
    input logic [DATA_WIDTH-1:0] rd,
    input logic [1:0]            size,
    input logic                  uns
  );
    logic s;
    s = ~uns;
    case (size)
      SZ_BYTE: load_ext = {{(DATA_WIDTH-8){s & rd[7]}}, rd[7:0]};
      SZ_HALF: load_ext = {{(DATA_WIDTH-16){s & rd[15]}}, rd[15:0]};
      default: load_ext = rd;
    endcase
  endfunction

  // Merge store data into the low bytes of the word read back from RAM
  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] rd,
    input logic [DATA_WIDTH-1:0] wd,
    input logic [1:0]            size
  );
    case (size)
      SZ_BYTE: merge_word = {rd[DATA_WIDTH-1:8], wd[7:0]};
      SZ_HALF: merge_word = {rd[DATA_WIDTH-1:16], wd[15:0]};
      default: merge_word = wd;
    endcase
  endfunction

  // Acceptance and alignment/size legality of the incoming request
  always_comb begin
    accept  = bus.req_valid && (state_q == IDLE);
    req_err = (bus.req_size == 2'b11) ||
              ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
              ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = RESP;
          end else if (!bus.req_write) begin
            state_d = LOAD;
          end else if (bus.req_size == SZ_WORD) begin
            state_d = STORE;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = STORE;
      STORE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and data capture next-state
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    if (accept) begin
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      size_d  = bus.req_size;
      uns_d   = bus.req_unsigned;
      err_d   = req_err;
      // Stores and errors respond with zero data
      rdata_d = '0;
      merge_d = '0;
    end
    if (state_q == LOAD) begin
      rdata_d = load_ext(bus.mem_read_data, size_q, uns_q);
    end
    if (state_q == RMW_RD) begin
      merge_d = merge_word(bus.mem_read_data, wdata_q, size_q);
    end
  end

  // Request latch and data capture registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
    end
  end

  // Outputs decoded from state only, so reset silences the RAM strobe at once
  always_comb begin
    bus.req_ready        = 1'b0;
    bus.rsp_valid        = 1'b0;
    bus.rsp_rdata        = '0;
    bus.rsp_err          = 1'b0;
    bus.mem_addr         = '0;
    bus.mem_write_enable = 1'b0;
    bus.mem_write_data   = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
      end
      LOAD, RMW_RD: begin
        bus.mem_addr = addr_q;
      end
      STORE: begin
        bus.mem_addr         = addr_q;
        bus.mem_write_enable = 1'b1;
        bus.mem_write_data   = (size_q == SZ_WORD) ? wdata_q : merge_q;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-byte little-endian RAM model.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Each test task does its own comparisons; one summary line at the end.
module tb_load_store_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: combinational 4-byte read at mem_addr, clocked 4-byte write
  logic [7:0] mem [0:63];
  logic [5:0] ra;
  assign ra = bus.mem_addr[5:0];
  assign bus.mem_read_data = {mem[ra + 6'd3], mem[ra + 6'd2], mem[ra + 6'd1], mem[ra]};

  always @(posedge clk) begin
    if (bus.mem_write_enable) begin
      mem[ra]        <= bus.mem_write_data[7:0];
      mem[ra + 6'd1] <= bus.mem_write_data[15:8];
      mem[ra + 6'd2] <= bus.mem_write_data[23:16];
      mem[ra + 6'd3] <= bus.mem_write_data[31:24];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] peek(input logic [5:0] a);
    return {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
  endfunction

  task automatic poke(input logic [5:0] a, input logic [31:0] d);
    mem[a]        = d[7:0];
    mem[a + 6'd1] = d[15:8];
    mem[a + 6'd2] = d[23:16];
    mem[a + 6'd3] = d[31:24];
  endtask

  // Results of the last single request
  logic        r_acc;
  int          r_lat;
  logic [31:0] r_rdata;
  logic        r_err;
  int          r_we_cnt;
  logic [31:0] r_we_addr;
  logic        r_pulse_ok;

  // Issue one request, measure response cycle (acceptance cycle = 0)
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    r_acc      = bus.req_ready;
    r_lat      = -1;
    r_rdata    = '0;
    r_err      = 1'b0;
    r_we_cnt   = 0;
    r_we_addr  = '0;
    r_pulse_ok = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus.mem_write_enable) begin
        r_we_cnt++;
        r_we_addr = bus.mem_addr;
      end
      if (bus.rsp_valid) begin
        r_lat   = n;
        r_rdata = bus.rsp_rdata;
        r_err   = bus.rsp_err;
        break;
      end
    end
    @(negedge clk);
    r_pulse_ok = !bus.rsp_valid;
  endtask

  task automatic test_reset();
    rst              = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_write_enable} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/vld/err/we=%b required 1000",
               {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_write_enable});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_write_data, bus.rsp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h required all 0",
               bus.mem_addr, bus.mem_write_data, bus.rsp_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_word();
    do_req(1'b1, 2'b10, 1'b0, 32'h04, 32'hDEADBEEF);
    checks++;
    if (r_acc !== 1'b1 || r_lat != 2 || r_err !== 1'b0 || r_rdata !== 32'h0) begin
      errors++;
      $display("FAIL st_word_rsp: got acc=%b lat=%0d err=%b rdata=%h required 1/2/0/0",
               r_acc, r_lat, r_err, r_rdata);
    end
    checks++;
    if (r_we_cnt != 1 || r_we_addr !== 32'h04) begin
      errors++;
      $display("FAIL st_word_we: got cycles=%0d addr=%h required 1 cycle at 00000004",
               r_we_cnt, r_we_addr);
    end
    checks++;
    if (peek(6'h04) !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL st_word_mem: got %h required deadbeef", peek(6'h04));
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    checks++;
    if (r_lat != 2 || r_err !== 1'b0 || r_rdata !== 32'hDEADBEEF || r_pulse_ok !== 1'b1) begin
      errors++;
      $display("FAIL ld_word: got lat=%0d err=%b rdata=%h pulse_ok=%b required 2/0/deadbeef/1",
               r_lat, r_err, r_rdata, r_pulse_ok);
    end
  endtask

  task automatic test_subword();
    poke(6'h08, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h08, 32'hFFFFFFAB);
    checks++;
    if (r_lat != 3 || r_err !== 1'b0 || r_we_cnt != 1) begin
      errors++;
      $display("FAIL st_byte_rsp: got lat=%0d err=%b we_cycles=%0d required 3/0/1",
               r_lat, r_err, r_we_cnt);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    checks++;
    if (r_rdata !== 32'h112233AB) begin
      errors++;
      $display("FAIL st_byte_data: got %h required 112233ab", r_rdata);
    end
    do_req(1'b1, 2'b01, 1'b0, 32'h08, 32'h1234CAFE);
    checks++;
    if (r_lat != 3 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL st_half_rsp: got lat=%0d err=%b required 3/0", r_lat, r_err);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    checks++;
    if (r_rdata !== 32'h1122CAFE) begin
      errors++;
      $display("FAIL st_half_data: got %h required 1122cafe", r_rdata);
    end
    // Byte store at an odd address only touches that byte
    poke(6'h10, 32'h00000000);
    poke(6'h14, 32'h99887766);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000005A);
    checks++;
    if (peek(6'h10) !== 32'h00005A00 || peek(6'h14) !== 32'h99887766) begin
      errors++;
      $display("FAIL st_byte_odd: got %h %h required 00005a00 99887766",
               peek(6'h10), peek(6'h14));
    end
  endtask

  task automatic test_sign();
    logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        us  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exp [4] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h000080F0};
    poke(6'h0C, 32'h000080F0);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sz[i], us[i], 32'h0C, 32'hFFFFFFFF);
      checks++;
      if (r_lat != 2 || r_err !== 1'b0 || r_rdata !== exp[i]) begin
        errors++;
        $display("FAIL ld_ext_%0d: got lat=%0d err=%b rdata=%h required 2/0/%h",
                 i, r_lat, r_err, r_rdata, exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic        wr  [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  sz  [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] ad  [3] = '{32'h01, 32'h06, 32'h00};
    poke(6'h00, 32'h01020304);
    for (int i = 0; i < 3; i++) begin
      do_req(wr[i], sz[i], 1'b0, ad[i], 32'h55555555);
      checks++;
      if (r_lat != 1 || r_err !== 1'b1 || r_rdata !== 32'h0 || r_we_cnt != 0) begin
        errors++;
        $display("FAIL err_%0d: got lat=%0d err=%b rdata=%h we_cycles=%0d required 1/1/0/0",
                 i, r_lat, r_err, r_rdata, r_we_cnt);
      end
    end
    checks++;
    if (peek(6'h00) !== 32'h01020304 || peek(6'h04) !== 32'hDEADBEEF ||
        peek(6'h08) !== 32'h1122CAFE) begin
      errors++;
      $display("FAIL err_mem: got %h %h %h required 01020304 deadbeef 1122cafe",
               peek(6'h00), peek(6'h04), peek(6'h08));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ad  [3] = '{32'h04, 32'h0C, 32'h08};
    logic [31:0] exp [3] = '{32'hDEADBEEF, 32'h000080F0, 32'h1122CAFE};
    int idx = 0;
    int acc_cnt = 0;
    int rdy_cnt = 0;
    int rsp_cnt = 0;
    int acc_cyc [3] = '{0, 0, 0};
    logic rdy;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = ad[0];
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (bus.rsp_valid) begin
        checks++;
        if (rsp_cnt > 2 || bus.rsp_rdata !== exp[rsp_cnt]) begin
          errors++;
          $display("FAIL b2b_rsp_%0d: got %h required %h", rsp_cnt, bus.rsp_rdata,
                   exp[rsp_cnt % 3]);
        end
        rsp_cnt++;
      end
      rdy = bus.req_ready;
      if (rdy && bus.req_valid) rdy_cnt++;
      @(posedge clk);
      if (rdy && bus.req_valid) begin
        acc_cyc[acc_cnt % 3] = cyc;
        acc_cnt++;
        #1;
        idx++;
        if (idx < 3) bus.req_addr = ad[idx];
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    checks++;
    if (acc_cnt != 3 || rdy_cnt != 3 || rsp_cnt != 3) begin
      errors++;
      $display("FAIL b2b_counts: got acc=%0d ready=%0d rsp=%0d required 3/3/3",
               acc_cnt, rdy_cnt, rsp_cnt);
    end
    checks++;
    if (acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d %0d %0d required 3 cycles apart",
               acc_cyc[0], acc_cyc[1], acc_cyc[2]);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_rsp = 1'b0;
    poke(6'h20, 32'hA1B2C3D4);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h00000077;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.mem_write_enable !== 1'b1) begin
      errors++;
      $display("FAIL rmid_in_store: got we=%b required 1", bus.mem_write_enable);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL rmid_we_drop: got we=%b required 0", bus.mem_write_enable);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_rsp = 1'b1;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_rsp = 1'b1;
    end
    checks++;
    if (seen_rsp !== 1'b0 || peek(6'h20) !== 32'hA1B2C3D4) begin
      errors++;
      $display("FAIL rmid_effect: got rsp_seen=%b mem=%h required 0 a1b2c3d4",
               seen_rsp, peek(6'h20));
    end
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_write_enable} !== 4'b1000 ||
        {bus.mem_addr, bus.mem_write_data, bus.rsp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL rmid_outputs: got rdy/vld/err/we=%b addr=%h wdata=%h rdata=%h required 1000 and zeros",
               {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_write_enable},
               bus.mem_addr, bus.mem_write_data, bus.rsp_rdata);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_word();
    test_subword();
    test_sign();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
